multi_cycle_control_fsm: RTL and testbench

Main sequencing controller for the multi-cycle RV32I CPU. It steps each instruction through IF, ID, EX, MEM and WB over a single shared ALU and a single shared memory port. Per cycle it drives the datapath mux selects, the register/PC/IR write enables, and the coarse ALU mode (`alu_op_sel`), which the ALU control unit refines using func3/func7. It stalls on a variable-latency memory handshake and halts on a terminating ECALL.

---
 rtl/multi_cycle_control_fsm.sv | 187 ++++++++++++++++++
 tb/tb_multi_cycle_control_fsm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_fsm.sv
// rtl/multi_cycle_control_fsm.sv - IF/ID/EX/MEM/WB sequencing controller for the multi-cycle RV32I core
module multi_cycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       halt_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op_sel,
  output logic       instr_retired,
  output logic       is_halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op_sel    = 2'b00;
    instr_retired = 1'b0;
    is_halted     = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = S_ID;
        end
      end
      S_ID: begin
        // ALUOut captures old_pc + imm for a later branch/JAL
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_SYSTEM: begin
            if (halt_cond) state_d = S_HALT;
            else begin
              instr_retired = 1'b1;
              state_d       = S_IF;
            end
          end
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
          default: begin
            instr_retired = 1'b1;
            state_d       = S_IF;
          end
        endcase
      end
      S_EX: begin
        state_d = S_IF;
        case (opcode)
          OP_R: begin
            alu_src_a  = 2'b01;
            alu_op_sel = 2'b10;
            state_d    = S_WB;
          end
          OP_I: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            alu_op_sel = 2'b10;
            state_d    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a     = 2'b01;
            alu_op_sel    = 2'b01;
            pc_write      = alu_bcond;
            pc_source     = 1'b1;
            instr_retired = 1'b1;
          end
          OP_JAL: begin
            reg_write     = 1'b1;
            wb_sel        = 2'b10;
            pc_write      = 1'b1;
            pc_source     = 1'b1;
            instr_retired = 1'b1;
          end
          OP_JALR: begin
            // rd takes the PC before this edge (old_pc + 4) while PC loads rs1 + imm
            alu_src_a     = 2'b01;
            alu_src_b     = 2'b10;
            pc_write      = 1'b1;
            reg_write     = 1'b1;
            wb_sel        = 2'b10;
            instr_retired = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else if (opcode == OP_STORE) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_retired = 1'b1;
            state_d       = S_IF;
          end
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        wb_sel        = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        state_d       = S_IF;
      end
      S_HALT: begin
        is_halted = 1'b1;
      end
      default: state_d = S_IF;
    endcase

    // Nothing may leave the controller while reset is held low
    if (!reset) begin
      pc_write      = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op_sel    = 2'b00;
      instr_retired = 1'b0;
      is_halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// tb/tb_multi_cycle_control_fsm.sv - directed bench for multi_cycle_control_fsm
module tb_multi_cycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       halt_cond;
  logic       mem_ready;
  logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op_sel;
  logic       instr_retired, is_halted;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_cycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
    .halt_cond(halt_cond), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .instr_retired(instr_retired), .is_halted(is_halted), .state(state)
  );

  // Field order: pw ps iod mr mw irw rw wb(2) a(2) b(2) op(2) ret halt st(3)
  logic [19:0] obs;
  assign obs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op_sel, instr_retired, is_halted, state};

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [19:0] E_IF_GO   = 20'b1_0_0_1_0_1_0_00_00_01_00_0_0_000;
  localparam logic [19:0] E_IF_WAIT = 20'b0_0_0_1_0_0_0_00_00_00_00_0_0_000;
  localparam logic [19:0] E_ID      = 20'b0_0_0_0_0_0_0_00_10_10_00_0_0_001;
  localparam logic [19:0] E_ID_RET  = 20'b0_0_0_0_0_0_0_00_10_10_00_1_0_001;
  localparam logic [19:0] E_EX_R    = 20'b0_0_0_0_0_0_0_00_01_00_10_0_0_010;
  localparam logic [19:0] E_EX_LS   = 20'b0_0_0_0_0_0_0_00_01_10_00_0_0_010;
  localparam logic [19:0] E_EX_BNT  = 20'b0_1_0_0_0_0_0_00_01_00_01_1_0_010;
  localparam logic [19:0] E_EX_BT   = 20'b1_1_0_0_0_0_0_00_01_00_01_1_0_010;
  localparam logic [19:0] E_EX_JALR = 20'b1_0_0_0_0_0_1_10_01_10_00_1_0_010;
  localparam logic [19:0] E_EX_JAL  = 20'b1_1_0_0_0_0_1_10_00_00_00_1_0_010;
  localparam logic [19:0] E_MEM_LD  = 20'b0_0_1_1_0_0_0_00_00_00_00_0_0_011;
  localparam logic [19:0] E_MEM_ST  = 20'b0_0_1_0_1_0_0_00_00_00_00_0_0_011;
  localparam logic [19:0] E_MEM_STR = 20'b0_0_1_0_1_0_0_00_00_00_00_1_0_011;
  localparam logic [19:0] E_WB_ALU  = 20'b0_0_0_0_0_0_1_00_00_00_00_1_0_100;
  localparam logic [19:0] E_WB_LD   = 20'b0_0_0_0_0_0_1_01_00_00_00_1_0_100;
  localparam logic [19:0] E_HALT    = 20'b0_0_0_0_0_0_0_00_00_00_00_0_1_101;
  localparam logic [19:0] E_ZERO    = 20'b0;

  task automatic chk(input string tag, input logic [19:0] exp);
    #1;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; opcode = OP_R; alu_bcond = 1'b0; halt_cond = 1'b0; mem_ready = 1'b1;
    step();
    chk("reset_gated", E_ZERO);
    reset = 1'b1;
    chk("add_if", E_IF_GO);
    step(); chk("add_id", E_ID);
    step(); chk("add_ex", E_EX_R);
    step(); chk("add_wb", E_WB_ALU);

    step(); opcode = OP_LOAD; mem_ready = 1'b0;
    chk("ld_if_wait", E_IF_WAIT);
    step(); chk("ld_if_wait2", E_IF_WAIT);
    mem_ready = 1'b1; chk("ld_if_go", E_IF_GO);
    step(); chk("ld_id", E_ID);
    step(); chk("ld_ex", E_EX_LS);
    step(); mem_ready = 1'b0; chk("ld_mem_w1", E_MEM_LD);
    step(); chk("ld_mem_w2", E_MEM_LD);
    step(); chk("ld_mem_w3", E_MEM_LD);
    step(); mem_ready = 1'b1; chk("ld_mem_go", E_MEM_LD);
    step(); chk("ld_wb", E_WB_LD);

    step(); opcode = OP_BRANCH; alu_bcond = 1'b0; chk("bnt_if", E_IF_GO);
    step(); chk("bnt_id", E_ID);
    step(); chk("bnt_ex", E_EX_BNT);
    step(); alu_bcond = 1'b1; chk("bt_if", E_IF_GO);
    step(); chk("bt_id", E_ID);
    step(); chk("bt_ex", E_EX_BT);

    step(); opcode = OP_JALR; chk("jalr_if", E_IF_GO);
    step(); chk("jalr_id", E_ID);
    step(); chk("jalr_ex", E_EX_JALR);
    step(); opcode = OP_JAL; chk("jal_if", E_IF_GO);
    step(); chk("jal_id", E_ID);
    step(); chk("jal_ex", E_EX_JAL);

    step(); opcode = OP_LUI; chk("nop_if", E_IF_GO);
    step(); chk("nop_id", E_ID_RET);

    step(); opcode = OP_STORE; chk("st_if", E_IF_GO);
    step(); chk("st_id", E_ID);
    step(); chk("st_ex", E_EX_LS);
    step(); chk("st_mem", E_MEM_STR);
    step(); chk("st_if_after", E_IF_GO);
    step(); chk("st2_id", E_ID);
    step(); chk("st2_ex", E_EX_LS);
    step(); mem_ready = 1'b0; chk("st2_mem_wait", E_MEM_ST);
    reset = 1'b0; chk("st2_reset_async", E_ZERO);
    step(); chk("st2_reset_hold", E_ZERO);
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_SYSTEM; halt_cond = 1'b0;
    chk("post_reset_if", E_IF_GO);

    step(); chk("ecall_id_ret", E_ID_RET);
    step(); halt_cond = 1'b1; chk("ecall2_if", E_IF_GO);
    step(); chk("ecall2_id", E_ID);
    step(); chk("halt1", E_HALT);
    mem_ready = 1'b0; opcode = OP_R;
    step(); chk("halt2", E_HALT);
    mem_ready = 1'b1;
    step(); chk("halt3", E_HALT);
    #2 reset = 1'b0;
    chk("halt_reset_async", E_ZERO);
    step(); reset = 1'b1; chk("halt_release_if", E_IF_GO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
